button_event_ctrl: RTL

//   Front-end controller for the board push buttons. It debounces N raw button

---
 rtl/button_event_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_ctrl.sv
// Push-button front end: synchronizes and debounces N raw buttons, runs a per-button
// press/hold/release FSM with auto-repeat and round-robins the events onto one stream.
module button_event_ctrl #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 100000,
    parameter int DB_DEPTH   = 4,
    parameter int LONG_TICKS = 500,
    parameter int REP_TICKS  = 100,
    localparam int ID_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_kind,
    output logic             overflow
);
    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HMAX   = (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
    localparam int HCNT_W = $clog2(HMAX + 1);

    localparam logic [1:0] ST_UP   = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] KIND_PRESS   = 2'b01;
    localparam logic [1:0] KIND_REPEAT  = 2'b10;
    localparam logic [1:0] KIND_RELEASE = 2'b11;

    logic [N_BTN-1:0]                  sync1_r;
    logic [N_BTN-1:0]                  sync2_r;
    logic [TCNT_W-1:0]                 tick_cnt_r;
    logic                              tick_s;
    logic [N_BTN-1:0][DB_DEPTH-1:0]    db_sh_r;
    logic [N_BTN-1:0][DB_DEPTH-1:0]    db_sh_nxt_s;
    logic [N_BTN-1:0]                  level_r;
    logic [N_BTN-1:0]                  level_nxt_s;
    logic [N_BTN-1:0][1:0]             state_r;
    logic [N_BTN-1:0][1:0]             state_nxt_s;
    logic [N_BTN-1:0][HCNT_W-1:0]      hcnt_r;
    logic [N_BTN-1:0][HCNT_W-1:0]      hcnt_nxt_s;
    logic [N_BTN-1:0]                  post_s;
    logic [N_BTN-1:0][1:0]             post_kind_s;
    logic [N_BTN-1:0]                  slot_valid_r;
    logic [N_BTN-1:0][1:0]             slot_kind_r;
    logic [N_BTN-1:0]                  take_s;
    logic [ID_W-1:0]                   last_grant_r;
    logic [ID_W-1:0]                   sel_id_s;
    logic                              sel_found_s;
    logic                              load_s;
    logic                              ovf_set_s;
    logic                              evt_valid_r;
    logic [ID_W-1:0]                   evt_id_r;
    logic [1:0]                        evt_kind_r;
    logic                              overflow_r;

    assign tick_s    = (tick_cnt_r == TCNT_W'(TICK_DIV - 1));
    assign load_s    = ~evt_valid_r | evt_ready;
    assign ovf_set_s = |(post_s & slot_valid_r & ~take_s);

    assign btn_level = level_r;
    assign evt_valid = evt_valid_r;
    assign evt_id    = evt_id_r;
    assign evt_kind  = evt_kind_r;
    assign overflow  = overflow_r;

    // Two-flop synchronizer for the asynchronous button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Sample-tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    // Debounce and press/hold/release FSM next-state, all gated by the tick
    always_comb begin
        logic [DB_DEPTH:0] shift_v;
        logic [HCNT_W-1:0] hinc_v;
        logic              rise_v;
        logic              fall_v;
        db_sh_nxt_s = db_sh_r;
        level_nxt_s = level_r;
        state_nxt_s = state_r;
        hcnt_nxt_s  = hcnt_r;
        post_s      = '0;
        post_kind_s = '0;
        shift_v     = '0;
        hinc_v      = '0;
        rise_v      = 1'b0;
        fall_v      = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            shift_v = {db_sh_r[i], sync2_r[i]};
            hinc_v  = hcnt_r[i] + 1'b1;
            if (tick_s) begin
                db_sh_nxt_s[i] = shift_v[DB_DEPTH-1:0];
                if (&shift_v[DB_DEPTH-1:0]) begin
                    level_nxt_s[i] = 1'b1;
                end else if (~|shift_v[DB_DEPTH-1:0]) begin
                    level_nxt_s[i] = 1'b0;
                end else begin
                    level_nxt_s[i] = level_r[i];
                end
                rise_v = level_nxt_s[i] & ~level_r[i];
                fall_v = ~level_nxt_s[i] & level_r[i];
                case (state_r[i])
                    ST_UP: begin
                        if (rise_v) begin
                            state_nxt_s[i] = ST_DOWN;
                            hcnt_nxt_s[i]  = '0;
                            post_s[i]      = 1'b1;
                            post_kind_s[i] = KIND_PRESS;
                        end else begin
                            state_nxt_s[i] = ST_UP;
                        end
                    end
                    ST_DOWN: begin
                        if (fall_v) begin
                            state_nxt_s[i] = ST_UP;
                            hcnt_nxt_s[i]  = '0;
                            post_s[i]      = 1'b1;
                            post_kind_s[i] = KIND_RELEASE;
                        end else if (hinc_v == HCNT_W'(LONG_TICKS)) begin
                            state_nxt_s[i] = ST_HOLD;
                            hcnt_nxt_s[i]  = '0;
                            post_s[i]      = 1'b1;
                            post_kind_s[i] = KIND_REPEAT;
                        end else begin
                            hcnt_nxt_s[i]  = hinc_v;
                        end
                    end
                    ST_HOLD: begin
                        if (fall_v) begin
                            state_nxt_s[i] = ST_UP;
                            hcnt_nxt_s[i]  = '0;
                            post_s[i]      = 1'b1;
                            post_kind_s[i] = KIND_RELEASE;
                        end else if (hinc_v == HCNT_W'(REP_TICKS)) begin
                            hcnt_nxt_s[i]  = '0;
                            post_s[i]      = 1'b1;
                            post_kind_s[i] = KIND_REPEAT;
                        end else begin
                            hcnt_nxt_s[i]  = hinc_v;
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_UP;
                        hcnt_nxt_s[i]  = '0;
                    end
                endcase
            end else begin
                state_nxt_s[i] = state_r[i];
            end
        end
    end

    // Per-button debounce, level and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_sh_r <= '0;
            level_r <= '0;
            state_r <= '0;
            hcnt_r  <= '0;
        end else begin
            db_sh_r <= db_sh_nxt_s;
            level_r <= level_nxt_s;
            state_r <= state_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
        end
    end

    // Round-robin pick: first pending slot after the last granted button
    always_comb begin
        logic [ID_W-1:0] idx_v;
        logic            hit_v;
        sel_found_s = 1'b0;
        sel_id_s    = '0;
        idx_v       = '0;
        hit_v       = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx_v       = ID_W'((int'(last_grant_r) + k) % N_BTN);
            hit_v       = slot_valid_r[idx_v] & ~sel_found_s;
            sel_id_s    = hit_v ? idx_v : sel_id_s;
            sel_found_s = sel_found_s | hit_v;
        end
        take_s           = '0;
        take_s[sel_id_s] = load_s & sel_found_s;
    end

    // Pending slots; a post over a slot not drained this cycle is an overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= '0;
            slot_kind_r  <= '0;
            overflow_r   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (post_s[i]) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_kind_r[i]  <= post_kind_s[i];
                end else if (take_s[i]) begin
                    slot_valid_r[i] <= 1'b0;
                end else begin
                    slot_valid_r[i] <= slot_valid_r[i];
                end
            end
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    // Output register, held stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_r  <= 1'b0;
            evt_id_r     <= '0;
            evt_kind_r   <= 2'b00;
            last_grant_r <= ID_W'(N_BTN - 1);
        end else if (load_s) begin
            if (sel_found_s) begin
                evt_valid_r  <= 1'b1;
                evt_id_r     <= sel_id_s;
                evt_kind_r   <= slot_kind_r[sel_id_s];
                last_grant_r <= sel_id_s;
            end else begin
                evt_valid_r  <= 1'b0;
            end
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

endmodule
